// File: rtl/tristate_bus_driver.sv
// tristate_bus_driver
//   Round-robin arbiter that places one of CHANNELS sources onto a shared
//   WIDTH-bit tri-state bus. The owner's data is registered (one cycle from
//   DIN to the bus) and optionally inverted. An all-Z turnaround of exactly
//   TURNAROUND cycles separates two owners so that drivers never overlap.
//
//   Optional feature macro: TSBUS_HOLD_TIMEOUT_EN
//     When defined, ownership is limited to MAX_HOLD cycles. A forced release
//     pulses TIMEOUT, and the released channel must drop REQ before it can be
//     granted again. When undefined, TIMEOUT is tied low and ownership is
//     unbounded.
//
// Ports:
//   CLK      in   clock, rising edge
//   RESET_N  in   asynchronous active-low reset
//   REQ      in   [CHANNELS]        per-channel level request
//   DIN      in   [CHANNELS*WIDTH]  channel i data in [i*WIDTH +: WIDTH]
//   GNT      out  [CHANNELS]        registered one-hot grant
//   BUS_OUT  out  [WIDTH]           tri-state bus, Z when not driving
//   BUS_OE   out                    high while BUS_OUT is driven
//   BUSY     out                    high in DRIVE or TURN
//   TIMEOUT  out                    one-cycle pulse on forced release
module tristate_bus_driver #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int INVERT     = 1,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 64
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [CHANNELS-1:0]       REQ,
  input  logic [CHANNELS*WIDTH-1:0] DIN,
  output logic [CHANNELS-1:0]       GNT,
  output logic [WIDTH-1:0]          BUS_OUT,
  output logic                      BUS_OE,
  output logic                      BUSY,
  output logic                      TIMEOUT
);

  localparam int IDX_W = $clog2(CHANNELS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Parameter range checks, evaluated at elaboration only.
  if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
    $error("tristate_bus_driver: CHANNELS must be 2..16");
  end
  if (TURNAROUND < 1 || TURNAROUND > 15) begin : g_bad_turnaround
    $error("tristate_bus_driver: TURNAROUND must be 1..15");
  end
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("tristate_bus_driver: MAX_HOLD must be at least 1");
  end

  state_t              state, state_n;
  logic [CHANNELS-1:0] gnt_n;
  logic [WIDTH-1:0]    data_reg, data_n;
  logic [IDX_W-1:0]    ptr, ptr_n;
  logic [IDX_W-1:0]    owner, owner_n;
  logic [IDX_W-1:0]    winner, cand;
  logic [3:0]          turn_cnt, turn_cnt_n;
  logic                found;
  logic                grant_now, release_now;
  logic [CHANNELS-1:0] eligible;
  logic [WIDTH-1:0]    din_ch [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_din_split
    assign din_ch[g] = DIN[g*WIDTH +: WIDTH];
  end

`ifdef TSBUS_HOLD_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
  logic [CHANNELS-1:0] blocked, blocked_n;
  logic                timeout_q;
  logic                force_now;

  // A channel that was forced off stays ineligible until it drops REQ.
  assign eligible = REQ & ~blocked;
  assign TIMEOUT  = timeout_q;
`else
  assign eligible = REQ;
  assign TIMEOUT  = 1'b0;
`endif

  // Rotating priority search: the first eligible channel at or after the
  // pointer, wrapping from CHANNELS-1 back to 0, wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = IDX_W'((int'(ptr) + i) % CHANNELS);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state logic. A release always takes priority over anything else
  // that happens on the same edge, so another channel raising REQ while the
  // owner drops it still waits out the full turnaround.
  always_comb begin
    state_n     = state;
    gnt_n       = GNT;
    data_n      = data_reg;
    ptr_n       = ptr;
    owner_n     = owner;
    turn_cnt_n  = turn_cnt;
    grant_now   = 1'b0;
    release_now = 1'b0;
`ifdef TSBUS_HOLD_TIMEOUT_EN
    force_now   = 1'b0;
    hold_cnt_n  = hold_cnt;
    blocked_n   = blocked & REQ;
`endif

    case (state)
      IDLE: grant_now = found;
      DRIVE: begin
        if (!REQ[owner]) begin
          release_now = 1'b1;
`ifdef TSBUS_HOLD_TIMEOUT_EN
        end else if (hold_cnt == HOLD_W'(MAX_HOLD)) begin
          release_now = 1'b1;
          force_now   = 1'b1;
`endif
        end else begin
          data_n = din_ch[owner];
        end
      end
      TURN: begin
        if (turn_cnt <= 4'd1) begin
          turn_cnt_n = '0;
          if (found) begin
            grant_now = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          turn_cnt_n = turn_cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (grant_now) begin
      state_n       = DRIVE;
      gnt_n         = '0;
      gnt_n[winner] = 1'b1;
      data_n        = din_ch[winner];
      owner_n       = winner;
      ptr_n         = (winner == IDX_W'(CHANNELS - 1)) ? '0 : winner + 1'b1;
    end

    if (release_now) begin
      state_n    = TURN;
      gnt_n      = '0;
      turn_cnt_n = 4'(TURNAROUND);
    end

`ifdef TSBUS_HOLD_TIMEOUT_EN
    // The grant cycle counts as the first owned cycle.
    if (grant_now) begin
      hold_cnt_n = HOLD_W'(1);
    end else if (release_now) begin
      hold_cnt_n = '0;
    end else if (state == DRIVE) begin
      hold_cnt_n = hold_cnt + 1'b1;
    end
    if (force_now) begin
      blocked_n[owner] = 1'b1;
    end
`endif
  end

  // Main state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      GNT      <= '0;
      data_reg <= '0;
      ptr      <= '0;
      owner    <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= state_n;
      GNT      <= gnt_n;
      data_reg <= data_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      turn_cnt <= turn_cnt_n;
    end
  end

`ifdef TSBUS_HOLD_TIMEOUT_EN
  // Hold-limit bookkeeping.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_cnt  <= '0;
      blocked   <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_cnt  <= hold_cnt_n;
      blocked   <= blocked_n;
      timeout_q <= force_now;
    end
  end
`endif

  // The bus is enabled exactly while in DRIVE, which only a grant enters.
  assign BUS_OE  = (state == DRIVE);
  assign BUSY    = (state != IDLE);
  assign BUS_OUT = BUS_OE ? ((INVERT != 0) ? ~data_reg : data_reg) : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tristate_bus_driver.sv
// tb_tristate_bus_driver
//   Self-checking bench for tristate_bus_driver. Each stimulus step pushes
//   the outputs expected after the next rising edge into a scoreboard queue;
//   the queue is drained and compared once the DUT has responded.
//   dut_a: WIDTH=8, CHANNELS=4, INVERT=1, TURNAROUND=2
//   dut_b: same, INVERT=0
//   dut_c: same as dut_a with MAX_HOLD=4 (TSBUS_HOLD_TIMEOUT_EN builds only)
module tb_tristate_bus_driver;

  logic        clk = 1'b0;
  logic        reset_n;

  logic [3:0]  req_a, gnt_a;
  logic [31:0] din_a;
  wire  [7:0]  bus_a;
  logic        oe_a, busy_a, tmo_a;

  logic [3:0]  req_b, gnt_b;
  logic [31:0] din_b;
  wire  [7:0]  bus_b;
  logic        oe_b, busy_b, tmo_b;

`ifdef TSBUS_HOLD_TIMEOUT_EN
  logic [3:0]  req_c, gnt_c;
  logic [31:0] din_c;
  wire  [7:0]  bus_c;
  logic        oe_c, busy_c, tmo_c;
`endif

  typedef struct {
    int         which;
    string      tag;
    logic [3:0] gnt;
    logic       oe;
    logic [7:0] bus;
    logic       busy;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  int   vector_count = 0;
  int   miss_count   = 0;

  always #5 clk = ~clk;

  tristate_bus_driver #(
    .WIDTH(8), .CHANNELS(4), .INVERT(1), .TURNAROUND(2), .MAX_HOLD(64)
  ) dut_a (
    .CLK(clk), .RESET_N(reset_n), .REQ(req_a), .DIN(din_a), .GNT(gnt_a),
    .BUS_OUT(bus_a), .BUS_OE(oe_a), .BUSY(busy_a), .TIMEOUT(tmo_a)
  );

  tristate_bus_driver #(
    .WIDTH(8), .CHANNELS(4), .INVERT(0), .TURNAROUND(2), .MAX_HOLD(64)
  ) dut_b (
    .CLK(clk), .RESET_N(reset_n), .REQ(req_b), .DIN(din_b), .GNT(gnt_b),
    .BUS_OUT(bus_b), .BUS_OE(oe_b), .BUSY(busy_b), .TIMEOUT(tmo_b)
  );

`ifdef TSBUS_HOLD_TIMEOUT_EN
  tristate_bus_driver #(
    .WIDTH(8), .CHANNELS(4), .INVERT(1), .TURNAROUND(2), .MAX_HOLD(4)
  ) dut_c (
    .CLK(clk), .RESET_N(reset_n), .REQ(req_c), .DIN(din_c), .GNT(gnt_c),
    .BUS_OUT(bus_c), .BUS_OE(oe_c), .BUSY(busy_c), .TIMEOUT(tmo_c)
  );
`endif

  // Single comparison point: counts every comparison, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input int which, input string tag, input logic [3:0] gnt,
                            input logic oe, input logic [7:0] bus, input logic busy,
                            input logic tmo);
    exp_t e;
    e.which = which;
    e.tag   = tag;
    e.gnt   = gnt;
    e.oe    = oe;
    e.bus   = bus;
    e.busy  = busy;
    e.tmo   = tmo;
    exp_q.push_back(e);
  endtask

  // Pop every pending expectation and compare it with the selected DUT.
  task automatic drainScoreboard();
    exp_t       e;
    logic [3:0] g;
    logic [7:0] b;
    logic       o, bz, t;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      g  = gnt_a;
      o  = oe_a;
      b  = bus_a;
      bz = busy_a;
      t  = tmo_a;
      if (e.which == 1) begin
        g  = gnt_b;
        o  = oe_b;
        b  = bus_b;
        bz = busy_b;
        t  = tmo_b;
      end
`ifdef TSBUS_HOLD_TIMEOUT_EN
      if (e.which == 2) begin
        g  = gnt_c;
        o  = oe_c;
        b  = bus_c;
        bz = busy_c;
        t  = tmo_c;
      end
`endif
      checkOutput({e.tag, ".gnt"},     32'(g),  32'(e.gnt));
      checkOutput({e.tag, ".oe"},      32'(o),  32'(e.oe));
      checkOutput({e.tag, ".bus"},     32'(b),  32'(e.bus));
      checkOutput({e.tag, ".busy"},    32'(bz), 32'(e.busy));
      checkOutput({e.tag, ".timeout"}, 32'(t),  32'(e.tmo));
    end
  endtask

  // Drive one cycle of inputs, record what must appear after the edge,
  // then sample just past the edge.
  task automatic applyStimulus(input int which, input string tag, input logic [3:0] req,
                               input logic [31:0] din, input logic [3:0] gnt,
                               input logic oe, input logic [7:0] bus, input logic busy,
                               input logic tmo);
    if (which == 0) begin
      req_a = req;
      din_a = din;
    end else if (which == 1) begin
      req_b = req;
      din_b = din;
`ifdef TSBUS_HOLD_TIMEOUT_EN
    end else begin
      req_c = req;
      din_c = din;
`endif
    end
    pushExpect(which, tag, gnt, oe, bus, busy, tmo);
    @(posedge clk);
    #1;
    drainScoreboard();
  endtask

  // Check outputs without waiting for an edge.
  task automatic expectNow(input int which, input string tag, input logic [3:0] gnt,
                           input logic oe, input logic [7:0] bus, input logic busy);
    pushExpect(which, tag, gnt, oe, bus, busy, 1'b0);
    drainScoreboard();
  endtask

  logic [31:0] rr_word;
  logic [7:0]  zz;

  initial begin
    rr_word = 32'h44332211;
    zz      = 8'hzz;
    reset_n = 1'b0;
    req_a   = '0;
    din_a   = '0;
    req_b   = '0;
    din_b   = '0;
`ifdef TSBUS_HOLD_TIMEOUT_EN
    req_c   = '0;
    din_c   = '0;
`endif

    #12;
    expectNow(0, "reset.a", 4'b0000, 1'b0, zz, 1'b0);
    expectNow(1, "reset.b", 4'b0000, 1'b0, zz, 1'b0);
    #6 reset_n = 1'b1;

    // Single request, then DIN change seen one edge later, then release.
    applyStimulus(0, "single.grant",   4'b0001, 32'h000000A5, 4'b0001, 1'b1, 8'h5A, 1'b1, 1'b0);
    applyStimulus(0, "single.din",     4'b0001, 32'h0000000F, 4'b0001, 1'b1, 8'hF0, 1'b1, 1'b0);
    applyStimulus(0, "single.release", 4'b0000, 32'h0000000F, 4'b0000, 1'b0, zz,    1'b1, 1'b0);
    applyStimulus(0, "single.turn",    4'b0000, 32'h0000000F, 4'b0000, 1'b0, zz,    1'b1, 1'b0);
    applyStimulus(0, "single.idle",    4'b0000, 32'h0000000F, 4'b0000, 1'b0, zz,    1'b0, 1'b0);

    // Reset while ch1 drives: outputs must clear before the next edge.
    applyStimulus(0, "rst.grant", 4'b0010, 32'h00003C00, 4'b0010, 1'b1, 8'hC3, 1'b1, 1'b0);
    #3 reset_n = 1'b0;
    #1 expectNow(0, "rst.async", 4'b0000, 1'b0, zz, 1'b0);
    #2 reset_n = 1'b1;

    // Round robin with all channels requesting; pointer restarts at 0.
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        applyStimulus(0, $sformatf("rr.own%0d", k), 4'b1111, rr_word,
                      4'(4'b0001 << k), 1'b1, ~rr_word[k*8 +: 8], 1'b1, 1'b0);
      end
      applyStimulus(0, $sformatf("rr.rel%0d", k), 4'b1111 & ~(4'b0001 << k), rr_word,
                    4'b0000, 1'b0, zz, 1'b1, 1'b0);
      applyStimulus(0, $sformatf("rr.gap%0d", k), 4'b1111, rr_word,
                    4'b0000, 1'b0, zz, 1'b1, 1'b0);
    end
    applyStimulus(0, "rr.wrap",    4'b1111, rr_word, 4'b0001, 1'b1, 8'hEE, 1'b1, 1'b0);
    applyStimulus(0, "rr.release", 4'b0000, rr_word, 4'b0000, 1'b0, zz,    1'b1, 1'b0);
    applyStimulus(0, "rr.turn",    4'b0000, rr_word, 4'b0000, 1'b0, zz,    1'b1, 1'b0);
    applyStimulus(0, "rr.idle",    4'b0000, rr_word, 4'b0000, 1'b0, zz,    1'b0, 1'b0);

    // Turnaround between ch2 and a waiting ch3: two Z cycles, no overlap.
    applyStimulus(0, "ta.grant2",  4'b0100, rr_word, 4'b0100, 1'b1, 8'hCC, 1'b1, 1'b0);
    applyStimulus(0, "ta.hold2",   4'b1100, rr_word, 4'b0100, 1'b1, 8'hCC, 1'b1, 1'b0);
    applyStimulus(0, "ta.release", 4'b1000, rr_word, 4'b0000, 1'b0, zz,    1'b1, 1'b0);
    applyStimulus(0, "ta.gap",     4'b1000, rr_word, 4'b0000, 1'b0, zz,    1'b1, 1'b0);
    applyStimulus(0, "ta.grant3",  4'b1000, rr_word, 4'b1000, 1'b1, 8'hBB, 1'b1, 1'b0);
    applyStimulus(0, "ta.drop3",   4'b0000, rr_word, 4'b0000, 1'b0, zz,    1'b1, 1'b0);
    applyStimulus(0, "ta.turn",    4'b0000, rr_word, 4'b0000, 1'b0, zz,    1'b1, 1'b0);
    applyStimulus(0, "ta.idle",    4'b0000, rr_word, 4'b0000, 1'b0, zz,    1'b0, 1'b0);

    // Non-inverting instance passes data through unchanged.
    applyStimulus(1, "inv0.grant",   4'b0010, 32'h00008100, 4'b0010, 1'b1, 8'h81, 1'b1, 1'b0);
    applyStimulus(1, "inv0.release", 4'b0000, 32'h00008100, 4'b0000, 1'b0, zz,    1'b1, 1'b0);

`ifdef TSBUS_HOLD_TIMEOUT_EN
    // ch0 holds past MAX_HOLD while ch2 waits: forced release then ch2.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(2, $sformatf("hold.own%0d", c), 4'b0101, 32'h00770055,
                    4'b0001, 1'b1, 8'hAA, 1'b1, 1'b0);
    end
    applyStimulus(2, "hold.forced", 4'b0101, 32'h00770055, 4'b0000, 1'b0, zz,    1'b1, 1'b1);
    applyStimulus(2, "hold.gap",    4'b0101, 32'h00770055, 4'b0000, 1'b0, zz,    1'b1, 1'b0);
    applyStimulus(2, "hold.grant2", 4'b0101, 32'h00770055, 4'b0100, 1'b1, 8'h88, 1'b1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
